// File: rtl/rca_serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rca_serial_add_ctrl_pkg : shared FSM encoding and adder slice width
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rca_serial_add_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rca_serial_add_ctrl_ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder : purely combinational 4-bit ripple-carry adder slice
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ripple_carry_adder
  import rca_serial_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/rca_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// rca_serial_add_ctrl : WIDTH-bit add by reusing one 4-bit slice per cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rca_serial_add_ctrl
  import rca_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(NSLICE - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [CNT_W-1:0]   r_cnt;
  logic [SLICE_W-1:0] w_s;
  logic               w_co;

  ripple_carry_adder u_rca (
    .a    (r_a[SLICE_W-1:0]),
    .b    (r_b[SLICE_W-1:0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == C_CNT_LAST) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
          end
        end
        RUN: begin
          // Slice results enter at the top so the LS nibble ends at bit 0.
          r_sum   <= (r_sum >> SLICE_W) | (WIDTH'(w_s) << (WIDTH - SLICE_W));
          r_a     <= r_a >> SLICE_W;
          r_b     <= r_b >> SLICE_W;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == C_CNT_LAST) r_cout <= w_co;
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_rca_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rca_serial_add_ctrl : WIDTH=4/16/32 instances against an arithmetic model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rca_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        cin_i = 1'b0;

  logic [2:0]  done_v, busy_v, cout_v;
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [31:0] sum_v [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rca_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a32[3:0]), .b(b32[3:0]), .cin(cin_i),
    .busy(busy_v[0]), .done(done_v[0]), .sum(s4), .cout(cout_v[0]));
  rca_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .a(a32[15:0]), .b(b32[15:0]), .cin(cin_i),
    .busy(busy_v[1]), .done(done_v[1]), .sum(s16), .cout(cout_v[1]));
  rca_serial_add_ctrl #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .a(a32), .b(b32), .cin(cin_i),
    .busy(busy_v[2]), .done(done_v[2]), .sum(s32), .cout(cout_v[2]));

  assign sum_v[0] = {28'd0, s4};
  assign sum_v[1] = {16'd0, s16};
  assign sum_v[2] = s32;

  function automatic int wid(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 16 : 32);
  endfunction

  // {cout,sum} as a plain unsigned sum of the operands truncated to w bits.
  function automatic logic [32:0] ref_add(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic c);
    logic [32:0] m;
    m = (33'd1 << w) - 33'd1;
    return ({1'b0, x} & m) + ({1'b0, y} & m) + {32'd0, c};
  endfunction

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("%s_busy_w%0d", tag, wid(i)), 64'(busy_v[i]), 64'd0);
      chk_eq($sformatf("%s_done_w%0d", tag, wid(i)), 64'(done_v[i]), 64'd0);
      chk_eq($sformatf("%s_sum_w%0d",  tag, wid(i)), 64'(sum_v[i]),  64'd0);
      chk_eq($sformatf("%s_cout_w%0d", tag, wid(i)), 64'(cout_v[i]), 64'd0);
    end
  endtask

  // One operation on all three widths; checks latency, result, pulse width,
  // busy length and that the result holds afterwards.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv);
    logic [32:0] r;
    logic [31:0] exp_sum [3];
    logic        exp_co  [3];
    bit          seen    [3];
    int          busy_n  [3];
    int          done_n  [3];
    for (int i = 0; i < 3; i++) begin
      r          = ref_add(wid(i), av, bv, cv);
      exp_sum[i] = r[31:0] & ((wid(i) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(i)) - 32'd1));
      exp_co[i]  = r[wid(i)];
      seen[i]    = 1'b0;
      busy_n[i]  = 0;
      done_n[i]  = 0;
    end
    @(negedge clk);
    a32 = av; b32 = bv; cin_i = cv; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a32 = $urandom; b32 = $urandom; cin_i = 1'($urandom);
      end
      for (int i = 0; i < 3; i++) begin
        if (busy_v[i]) busy_n[i]++;
        if (done_v[i]) begin
          done_n[i]++;
          if (!seen[i]) begin
            seen[i] = 1'b1;
            chk_eq($sformatf("lat_w%0d", wid(i)), 64'(k), 64'(wid(i) / 4 + 1));
            chk_eq($sformatf("sum_w%0d", wid(i)), 64'(sum_v[i]), 64'(exp_sum[i]));
            chk_eq($sformatf("cout_w%0d", wid(i)), 64'(cout_v[i]), 64'(exp_co[i]));
          end
        end else if (seen[i]) begin
          chk_eq($sformatf("hold_sum_w%0d", wid(i)), 64'(sum_v[i]), 64'(exp_sum[i]));
          chk_eq($sformatf("hold_cout_w%0d", wid(i)), 64'(cout_v[i]), 64'(exp_co[i]));
        end
      end
      if (seen[0] && seen[1] && seen[2] && done_v == 3'b000) break;
    end
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("done_seen_w%0d", wid(i)), 64'(seen[i]), 64'd1);
      chk_eq($sformatf("done_width_w%0d", wid(i)), 64'(done_n[i]), 64'd1);
      chk_eq($sformatf("busy_len_w%0d", wid(i)), 64'(busy_n[i]), 64'(wid(i) / 4 + 1));
    end
  endtask

  initial begin
    int n_done;
    logic [31:0] ra, rb;

    pulse_reset(3);
    check_idle_zero("reset");

    run_op(32'h0000_0000, 32'h0000_0000, 1'b0);
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    chk_eq("d_00ff_sum16", 64'(s16), 64'h0100);
    chk_eq("d_00ff_cout16", 64'(cout_v[1]), 64'd0);
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    chk_eq("d_ffff1_sum16", 64'(s16), 64'h0000);
    chk_eq("d_ffff1_cout16", 64'(cout_v[1]), 64'd1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk_eq("d_ffffff_sum16", 64'(s16), 64'hFFFF);
    chk_eq("d_ffffff_cout16", 64'(cout_v[1]), 64'd1);

    // start held high through two WIDTH=16 operations, operands changed in RUN
    @(negedge clk);
    a32 = 32'h1234; b32 = 32'h1111; cin_i = 1'b0; start = 1'b1;
    n_done = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a32 = 32'hAAAA; b32 = 32'h5555;
      end
      if (done_v[1]) begin
        n_done++;
        if (n_done == 1) begin
          chk_eq("hold_start_k1", 64'(k), 64'd5);
          chk_eq("hold_start_sum1", 64'(s16), 64'h2345);
          chk_eq("hold_start_cout1", 64'(cout_v[1]), 64'd0);
        end else begin
          chk_eq("hold_start_k2", 64'(k), 64'd11);
          chk_eq("hold_start_sum2", 64'(s16), 64'hFFFF);
          chk_eq("hold_start_cout2", 64'(cout_v[1]), 64'd0);
        end
      end
    end
    start = 1'b0;
    chk_eq("hold_start_ndone", 64'(n_done), 64'd2);
    chk_eq("hold_start_idle", 64'(busy_v[1]), 64'd0);
    pulse_reset(1);

    // reset mid-RUN when the WIDTH=16 counter reads 2
    @(negedge clk);
    a32 = 32'h0000_7777; b32 = 32'h0000_9999; cin_i = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("midrst");
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v != 3'b000) n_done++;
    end
    chk_eq("midrst_no_done", 64'(n_done), 64'd0);
    run_op(32'h0000_8000, 32'h0000_8000, 1'b0);
    chk_eq("d_8000_sum16", 64'(s16), 64'h0000);
    chk_eq("d_8000_cout16", 64'(cout_v[1]), 64'd1);

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ((n % 8) == 0) rb = ~ra;
      if ((n % 16) == 1) ra = 32'hFFFF_FFFF;
      run_op(ra, rb, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
